// File: rtl/count_capture_fifo_if.sv
// Capture/drain bus for count_capture_fifo: counter snapshot input side,
// reader valid/ready side and status outputs.
interface count_capture_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] count_in;
    logic             count_vld;
    logic             trig;
    logic             clr_ovf;
    logic             out_rdy;
    logic             out_vld;
    logic [WIDTH-1:0] out_count;
    logic [WIDTH-1:0] out_delta;
    logic [LW-1:0]    level;
    logic             overflow;

    // Driver of captures and reader of entries
    modport master (
        output count_in, count_vld, trig, clr_ovf, out_rdy,
        input  out_vld, out_count, out_delta, level, overflow
    );

    // The FIFO block itself
    modport slave (
        input  count_in, count_vld, trig, clr_ovf, out_rdy,
        output out_vld, out_count, out_delta, level, overflow
    );
endinterface

// File: rtl/count_capture_fifo.sv
// Counter snapshot FIFO: on a capture strobe stores {count, count - previous
// stored capture} in a DEPTH-entry FIFO drained by a valid/ready reader.
// A capture that finds the FIFO full (and no pop in the same cycle) is
// dropped and raises a sticky overflow flag.
module count_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    count_capture_fifo_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Pointer arithmetic relies on natural wrap, so DEPTH must be 2^n, n>=1
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("count_capture_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] last_cap_q, last_cap_d;
    logic             ovf_q, ovf_d;

    // Storage is deliberately not reset; level gates its visibility
    logic [WIDTH-1:0] mem_count_q [DEPTH];
    logic [WIDTH-1:0] mem_delta_q [DEPTH];

    logic             cap;
    logic             pop;
    logic             full;
    logic             push;
    logic             reject;
    logic             not_empty;
    logic [WIDTH-1:0] new_delta;

    // Handshake decode; out_vld derives from registered level only, so
    // there is no combinational path from trig to out_vld
    always_comb begin
        not_empty = (level_q != '0);
        full      = (level_q == LW'(DEPTH));
        cap       = bus.trig & bus.count_vld;
        pop       = not_empty & bus.out_rdy;
        push      = cap & (~full | pop);
        reject    = cap & full & ~pop;
        new_delta = bus.count_in - last_cap_q;
    end

    // Next-state for pointers, level, last capture and sticky overflow
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        last_cap_d = last_cap_q;
        ovf_d      = ovf_q;

        if (push) begin
            wr_ptr_d   = wr_ptr_q + AW'(1);
            last_cap_d = bus.count_in;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        // Simultaneous push and pop leaves level unchanged
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end

        // A dropped capture wins over a clear in the same cycle
        if (reject) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            last_cap_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            last_cap_q <= last_cap_d;
            ovf_q      <= ovf_d;
        end
    end

    // Entry write on accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            mem_count_q[wr_ptr_q] <= bus.count_in;
            mem_delta_q[wr_ptr_q] <= new_delta;
        end
    end

    // Head entry and status outputs
    always_comb begin
        bus.out_vld   = not_empty;
        bus.out_count = mem_count_q[rd_ptr_q];
        bus.out_delta = mem_delta_q[rd_ptr_q];
        bus.level     = level_q;
        bus.overflow  = ovf_q;
    end
endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed plus randomized bench for count_capture_fifo against a queue-based
// reference model of the capture/drain rules.
module tb_count_capture_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    count_capture_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    count_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: queue of {count, delta}, last stored capture, flag
    logic [2*WIDTH-1:0] mq[$];
    logic [WIDTH-1:0]   m_last = '0;
    logic               m_ovf  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_last = '0;
        m_ovf  = 1'b0;
    endtask

    // Compare all observable outputs against the model
    task automatic check_all(input string tag);
        chk({tag, ".vld"},   32'(bus.out_vld), 32'(mq.size() != 0));
        chk({tag, ".level"}, 32'(bus.level),   32'(mq.size()));
        chk({tag, ".ovf"},   32'(bus.overflow), 32'(m_ovf));
        if (mq.size() != 0) begin
            chk({tag, ".cnt"},   32'(bus.out_count), 32'(mq[0][2*WIDTH-1:WIDTH]));
            chk({tag, ".delta"}, 32'(bus.out_delta), 32'(mq[0][WIDTH-1:0]));
        end
    endtask

    // One clock: drive inputs, advance the model, check after the edge
    task automatic cyc(input bit t, input bit v, input bit r, input bit c,
                       input logic [WIDTH-1:0] cnt, input string tag);
        bit cap, pop, full;
        bus.trig      = t;
        bus.count_vld = v;
        bus.out_rdy   = r;
        bus.clr_ovf   = c;
        bus.count_in  = cnt;
        cap  = t && v;
        pop  = (mq.size() != 0) && r;
        full = (mq.size() == DEPTH);
        if (pop) void'(mq.pop_front());
        if (cap && (!full || pop)) begin
            mq.push_back({cnt, cnt - m_last});
            m_last = cnt;
        end else if (cap) begin
            m_ovf = 1'b1;
        end
        if (c && !(cap && full && !pop)) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic capture(input logic [WIDTH-1:0] cnt, input bit r, input string tag);
        cyc(1, 1, r, 0, cnt, tag);
    endtask

    task automatic idle(input bit r, input string tag);
        cyc(0, 0, r, 0, '0, tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1; i++) idle(1, tag);
    endtask

    initial begin
        bus.trig = 0; bus.count_vld = 0; bus.out_rdy = 0;
        bus.clr_ovf = 0; bus.count_in = '0;

        // Reset held three cycles, then idle
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst.vld", 32'(bus.out_vld), 0);
            chk("rst.level", 32'(bus.level), 0);
            chk("rst.ovf", 32'(bus.overflow), 0);
        end
        rst_n = 1'b1;
        idle(0, "idle");
        idle(0, "idle");

        // Single capture pair, then drain
        capture(8'h05, 0, "single");
        capture(8'h0C, 0, "single");
        chk("single.level2", 32'(bus.level), 2);
        chk("single.h0cnt", 32'(bus.out_count), 32'h05);
        chk("single.h0dlt", 32'(bus.out_delta), 32'h05);
        idle(1, "single.pop");
        chk("single.h1cnt", 32'(bus.out_count), 32'h0C);
        chk("single.h1dlt", 32'(bus.out_delta), 32'h07);
        drain("single.drain");

        // Wrap-around delta
        capture(8'hFE, 0, "wrap");
        capture(8'h02, 0, "wrap");
        idle(1, "wrap.pop");
        chk("wrap.delta", 32'(bus.out_delta), 32'h04);
        drain("wrap.drain");

        // Fill plus one rejected capture
        for (int i = 0; i < 5; i++) capture(8'(8'h10 + i), 0, "fill");
        chk("fill.level", 32'(bus.level), 4);
        chk("fill.ovf", 32'(bus.overflow), 1);
        for (int i = 0; i < 4; i++) begin
            chk("fill.head", 32'(bus.out_count), 32'(8'h10 + i));
            idle(1, "fill.drain");
        end
        chk("fill.empty", 32'(bus.out_vld), 0);
        capture(8'h20, 0, "after_fill");
        chk("after_fill.delta", 32'(bus.out_delta), 32'h0D);
        drain("after_fill.drain");

        // Full with simultaneous push and pop
        cyc(0, 0, 0, 1, '0, "clr");
        chk("clr.ovf", 32'(bus.overflow), 0);
        for (int i = 0; i < 4; i++) capture(8'(8'h40 + i), 0, "full");
        capture(8'h30, 1, "full.pushpop");
        chk("full.level", 32'(bus.level), 4);
        chk("full.ovf", 32'(bus.overflow), 0);
        for (int i = 0; i < 3; i++) idle(1, "full.drain");
        chk("full.last", 32'(bus.out_count), 32'h30);
        drain("full.drain");

        // Clear racing a rejected push, then clear alone
        for (int i = 0; i < 4; i++) capture(8'(8'h50 + i), 0, "ovfclr");
        cyc(1, 1, 0, 1, 8'h60, "ovfclr.race");
        chk("ovfclr.race", 32'(bus.overflow), 1);
        cyc(0, 0, 0, 1, '0, "ovfclr.alone");
        chk("ovfclr.alone", 32'(bus.overflow), 0);
        drain("ovfclr.drain");

        // Mid-run reset with three entries stored
        for (int i = 0; i < 3; i++) capture(8'(8'h70 + i), 0, "mrst");
        chk("mrst.level3", 32'(bus.level), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.vld", 32'(bus.out_vld), 0);
        chk("mrst.level", 32'(bus.level), 0);
        model_reset();
        @(posedge clk); #1;
        check_all("mrst.hold");
        rst_n = 1'b1;
        capture(8'h37, 0, "mrst.first");
        chk("mrst.delta", 32'(bus.out_delta), 32'h37);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 80,
                $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 10,
                8'($urandom), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/count_capture_fifo.md
# count_capture_fifo

Downstream consumer of the counter stage. On a capture strobe it samples the counter value, computes the modulo-2^WIDTH difference from the previous stored capture, and stores the pair in a DEPTH-entry FIFO. The reader drains entries through a valid/ready handshake. The block gives the test environment and later logic a buffered, loss-flagged record of counter snapshots without stalling the counter.

## Interface
- WIDTH, 8, counter value width.
- DEPTH, 4, FIFO entries. Must be a power of two and at least 2.
- clk  input  1  clock. All state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset. Release is synchronous to clk, supplied externally.
- count_in  input  WIDTH  current counter value.
- count_vld  input  1  count_in is valid this cycle.
- trig  input  1  capture request. Sampled only when count_vld=1.
- clr_ovf  input  1  clear the sticky overflow flag.
- out_rdy  input  1  reader accepts the head entry.
- out_vld  output  1  FIFO not empty.
- out_count  output  WIDTH  captured counter value at the head.
- out_delta  output  WIDTH  head capture minus previous stored capture, mod 2^WIDTH.
- level  output  $clog2(DEPTH)+1  current number of stored entries.
- overflow  output  1  sticky flag: a capture was dropped because the FIFO was full.

## Operation
- Capture request (cap): trig=1 and count_vld=1 in the same cycle. trig with count_vld=0 is ignored.
- Pop: out_vld=1 and out_rdy=1.
- Push accepted: cap=1 and (level<DEPTH, or a pop happens in the same cycle).
- Push accepted, the block does all of the following:
  - writes {count_in, count_in − last_cap} at wr_ptr;
  - sets last_cap ← count_in;
  - advances wr_ptr.
- Push rejected (cap=1, FIFO full, no pop):
  - the entry is discarded;
  - last_cap is unchanged;
  - overflow ← 1.
- Delta arithmetic is WIDTH-bit unsigned subtraction, wrap-around allowed. For example, 0x02 − 0xFE = 0x04.
- last_cap resets to 0, so the first delta after reset equals count_in.
- Pointers are log2(DEPTH) bits and wrap naturally. level is held in a separate counter:
  - +1 on push only;
  - −1 on pop only;
  - unchanged on simultaneous push and pop.
- Pop on an empty FIFO cannot occur because out_vld=0. out_rdy has no effect when out_vld=0.
- overflow is cleared by clr_ovf. If clr_ovf and a rejected push occur in the same cycle, set wins and overflow stays 1.
- Outputs driven by the head entry (out_count, out_delta) are undefined while out_vld=0. The bench must not check them in that state.
- Reader handshake rules:
  - once out_vld=1, the head entry is stable until popped;
  - out_vld never drops without a pop.
- Reset values: out_vld=0, level=0, overflow=0, wr_ptr=rd_ptr=0, last_cap=0. Memory contents are not reset.
- Reset asserted mid-operation: all stored entries are lost immediately (asynchronously). The state matches the reset values while rst_n=0.

## Timing
- Capture to visibility: one cycle. A push at edge N makes out_vld=1 after edge N, with head data valid in the same cycle.
- Pop: the entry is consumed at the edge where out_vld and out_rdy are both 1. The next entry, if any, appears after that edge, giving back-to-back throughput of one per cycle.
- Full with simultaneous push and pop: both complete at one edge. level stays at DEPTH and overflow is not set.
- Empty with a push: out_vld rises one cycle later. There is no combinational path from trig to out_vld.
- overflow rises the cycle after the rejected capture.
- clr_ovf takes effect at the next edge.
- level is registered and reflects all pushes and pops completed at the previous edge.

## Test plan
- **Reset and idle.** Hold rst_n=0 for 3 cycles, then release with no trig. Expect out_vld=0, level=0 and overflow=0 throughout.
- **Single capture.** Capture count_in=0x05, then 0x0C, with out_rdy=0. Expect level=2. Then set out_rdy=1 and expect head (0x05, 0x05) followed by (0x0C, 0x07).
- **Wrap-around delta.** Capture 0xFE, then 0x02. Expect the second entry's out_delta=0x04.
- **Fill and overflow.** Make 5 captures (0x10–0x14) with out_rdy=0. Expect:
  - level=4 and overflow=1;
  - draining yields 0x10–0x13 only;
  - the next capture 0x20 has delta 0x0D (0x20 − 0x13).
- **Full with simultaneous push and pop.** With the FIFO full and out_rdy=1, capture 0x30 in the same cycle as the pop. Expect:
  - level stays 4 and overflow is unchanged;
  - 0x30 drains last.
- **Overflow clear and mid-run reset.**
  - clr_ovf together with a rejected push: overflow stays 1. clr_ovf alone: overflow returns to 0.
  - Assert rst_n=0 with 3 entries stored: out_vld=0 and level=0 immediately. The first capture after reset gives delta=count_in.
